// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// The fetch stage looks up IF_pc combinationally and gets a predicted next PC.
// The MEM stage feeds back resolved control flow. That feedback trains the
// table, detects mispredictions, and keeps running statistics.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    // fetch-side lookup
    input  logic [31:0]       IF_pc,
    output logic              hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    // resolved control flow from the MEM stage
    input  logic              upd_valid,
    input  logic              upd_branch,
    input  logic              upd_jump,
    input  logic              upd_taken,
    input  logic [31:0]       upd_pc,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    // table maintenance
    input  logic              clear,
    // flush request back to the pipeline
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    // statistics
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mis_cnt
);

    localparam int IW = $clog2(ENTRIES);

    // Counter encodings: the MSB is the taken/not-taken decision.
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Flattened view of every entry, so both ports can index the table.
    logic [ENTRIES-1:0]             valid_vec;
    logic [ENTRIES-1:0]             jmp_vec;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_vec;
    logic [ENTRIES-1:0][31:0]       target_vec;
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_vec;

    // ------------------------------------------------------------------
    // Lookup port
    // ------------------------------------------------------------------
    logic [IW-1:0]    look_idx;
    logic [TAG_W-1:0] look_tag;
    logic [31:0]      look_seq_pc;

    assign look_idx    = IF_pc[IW+1:2];
    assign look_tag    = IF_pc[IW+1+TAG_W:IW+2];
    assign look_seq_pc = IF_pc + 32'd4;

    // Zero-latency prediction from the current table contents.
    always_comb begin
        hit         = valid_vec[look_idx] && (tag_vec[look_idx] == look_tag);
        pred_taken  = hit && (jmp_vec[look_idx] || ctr_vec[look_idx][CTR_W-1]);
        pred_target = look_seq_pc;
        if (pred_taken) begin
            pred_target = target_vec[look_idx];
        end
    end

    // ------------------------------------------------------------------
    // Update port decode
    // ------------------------------------------------------------------
    logic [IW-1:0]    upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_is_ctl;
    logic             ctl;
    logic             upd_hit;
    logic [31:0]      upd_seq_pc;

    assign upd_idx    = upd_pc[IW+1:2];
    assign upd_tag    = upd_pc[IW+1+TAG_W:IW+2];
    assign upd_is_ctl = upd_branch || upd_jump;
    assign ctl        = upd_valid && upd_is_ctl;
    assign upd_hit    = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
    assign upd_seq_pc = upd_pc + 32'd4;

    // Misprediction covers direction errors, wrong targets on correctly
    // predicted redirects, and a redirect predicted for a non-control
    // instruction (a stale alias in the table).
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = upd_seq_pc;
        if (upd_valid) begin
            if (upd_taken != upd_pred_taken) begin
                mispredict = 1'b1;
            end
            if (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)) begin
                mispredict = 1'b1;
            end
            if (!upd_is_ctl && upd_pred_taken) begin
                mispredict = 1'b1;
            end
        end
        if (ctl && upd_taken) begin
            redirect_pc = upd_target;
        end
    end

    // ------------------------------------------------------------------
    // Table entries
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             sel;
            logic             valid_reg,  valid_next;
            logic             jmp_reg,    jmp_next;
            logic [TAG_W-1:0] tag_reg,    tag_next;
            logic [31:0]      target_reg, target_next;
            logic [CTR_W-1:0] ctr_reg,    ctr_next;

            assign sel = upd_valid && (upd_idx == IW'(gi));

            // Training rule for this entry; clear wins over any update.
            always_comb begin
                valid_next  = valid_reg;
                jmp_next    = jmp_reg;
                tag_next    = tag_reg;
                target_next = target_reg;
                ctr_next    = ctr_reg;
                if (clear) begin
                    valid_next = 1'b0;
                    ctr_next   = CTR_WNT;
                end else if (sel && ctl) begin
                    if (upd_hit) begin
                        if (upd_taken) begin
                            if (ctr_reg != CTR_MAX) begin
                                ctr_next = ctr_reg + CTR_W'(1);
                            end
                            target_next = upd_target;
                            jmp_next    = upd_jump;
                        end else if (ctr_reg != '0) begin
                            ctr_next = ctr_reg - CTR_W'(1);
                        end
                    end else if (upd_taken) begin
                        // Only taken control flow earns a table slot.
                        valid_next  = 1'b1;
                        tag_next    = upd_tag;
                        target_next = upd_target;
                        jmp_next    = upd_jump;
                        ctr_next    = CTR_WT;
                    end
                end else if (sel && upd_hit) begin
                    // A non-control instruction matched: drop the alias.
                    valid_next = 1'b0;
                end
            end

            // Entry state; reset discards any pending write entirely.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    valid_reg  <= 1'b0;
                    jmp_reg    <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_WNT;
                end else begin
                    valid_reg  <= valid_next;
                    jmp_reg    <= jmp_next;
                    tag_reg    <= tag_next;
                    target_reg <= target_next;
                    ctr_reg    <= ctr_next;
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign jmp_vec[gi]    = jmp_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
            assign ctr_vec[gi]    = ctr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Statistics (unaffected by clear)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] br_cnt_reg;
    logic [CNT_W-1:0] mis_cnt_reg;

    // Saturating event counters for resolved control flow and mispredicts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt_reg  <= '0;
            mis_cnt_reg <= '0;
        end else begin
            if (ctl && (br_cnt_reg != CNT_MAX)) begin
                br_cnt_reg <= br_cnt_reg + CNT_W'(1);
            end
            if (mispredict && (mis_cnt_reg != CNT_MAX)) begin
                mis_cnt_reg <= mis_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign br_cnt  = br_cnt_reg;
    assign mis_cnt = mis_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (16 entries, 8-bit tag, 2-bit
// counters, 4-bit statistics so saturation is reachable).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] IF_pc;
    logic        hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_branch, upd_jump, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        clear;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  br_cnt, mis_cnt;

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES(16), .TAG_W(8), .CTR_W(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .IF_pc(IF_pc), .hit(hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_branch(upd_branch), .upd_jump(upd_jump),
        .upd_taken(upd_taken), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .clear(clear), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        uv, ub, uj, ut;
        logic [31:0] upc, utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        clr;
        logic        e_hit, e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_redir;
        int          e_br, e_mc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t cur_v, exp_v;
    int   errors = 0;
    int   checks = 0;
    int   exp_mc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic add(input logic [31:0] if_pc, input logic uv, input logic ub,
                       input logic uj, input logic ut, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                       input logic clr, input logic e_hit, input logic e_pt,
                       input logic [31:0] e_ptgt, input logic e_mis,
                       input logic [31:0] e_redir, input int e_br, input int e_mc);
        vec_t v;
        v.if_pc = if_pc; v.uv = uv; v.ub = ub; v.uj = uj; v.ut = ut;
        v.upc = upc; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt; v.clr = clr;
        v.e_hit = e_hit; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mis = e_mis;
        v.e_redir = e_redir; v.e_br = e_br; v.e_mc = e_mc;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        IF_pc = v.if_pc; upd_valid = v.uv; upd_branch = v.ub; upd_jump = v.uj;
        upd_taken = v.ut; upd_pc = v.upc; upd_target = v.utgt;
        upd_pred_taken = v.upt; upd_pred_target = v.uptgt; clear = v.clr;
    endtask

    task automatic idle(input logic [31:0] pc);
        IF_pc = pc; upd_valid = 0; upd_branch = 0; upd_jump = 0; upd_taken = 0;
        upd_pc = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0; clear = 0;
    endtask

    initial begin
        // Vectors: lookup/flush outputs are for the cycle the inputs are
        // applied (old table contents); counters are after that edge.
        //   if_pc   uv ub uj ut upc    utgt   upt uptgt  clr  hit pt ptgt   mis redir  br mc
        add(32'h40, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0,  0, 0, 32'h44, 0, 32'h4, 0, 0);
        add(32'h40, 1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h0, 0,  0, 0, 32'h44, 1, 32'h20, 1, 1);
        add(32'h40, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0,  1, 1, 32'h20, 0, 32'h4, 1, 1);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h0, 1, 32'h20, 0,  1, 1, 32'h20, 1, 32'h44, 2, 2);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h0, 0, 32'h0, 0,  1, 0, 32'h44, 0, 32'h44, 3, 2);
        add(32'h40, 1, 1, 0, 0, 32'h40, 32'h0, 0, 32'h0, 0,  1, 0, 32'h44, 0, 32'h44, 4, 2);
        add(32'h440, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h444, 0, 32'h4, 4, 2);
        add(32'h40, 1, 0, 0, 0, 32'h40, 32'h0, 1, 32'h20, 0,  1, 0, 32'h44, 1, 32'h44, 4, 3);
        add(32'h40, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0,  0, 0, 32'h44, 0, 32'h4, 4, 3);
        add(32'h80, 1, 0, 1, 1, 32'h80, 32'h100, 0, 32'h0, 0, 0, 0, 32'h84, 1, 32'h100, 5, 4);
        add(32'h80, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0,  1, 1, 32'h100, 0, 32'h4, 5, 4);
        add(32'h80, 1, 0, 1, 1, 32'h80, 32'h200, 1, 32'h100, 0, 1, 1, 32'h100, 1, 32'h200, 6, 5);
        add(32'h80, 1, 0, 1, 1, 32'h80, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200, 0, 32'h200, 7, 5);
        add(32'h84, 1, 1, 0, 0, 32'h84, 32'h0, 0, 32'h0, 0,  0, 0, 32'h88, 0, 32'h88, 8, 5);
        add(32'h84, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0,  0, 0, 32'h88, 0, 32'h4, 8, 5);
        add(32'h80, 1, 1, 0, 1, 32'h80, 32'h300, 1, 32'h200, 1, 1, 1, 32'h200, 1, 32'h300, 9, 6);
        add(32'h80, 0, 1, 0, 1, 32'h10, 32'h50, 0, 32'h0, 0,  0, 0, 32'h84, 0, 32'h14, 9, 6);
        add(32'h40, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0,  0, 0, 32'h44, 0, 32'h4, 9, 6);

        // Reset state while rstn is held low.
        rstn = 1'b0;
        idle(32'h40);
        repeat (2) @(negedge clk);
        check("reset_hit", 32'(hit), 32'h0);
        check("reset_pred_taken", 32'(pred_taken), 32'h0);
        check("reset_pred_target", pred_target, 32'h44);
        check("reset_br_cnt", 32'(br_cnt), 32'h0);
        check("reset_mis_cnt", 32'(mis_cnt), 32'h0);
        rstn = 1'b1;

        // Table-driven vectors through a scoreboard queue.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cur_v = vecs[i];
            drive(cur_v);
            sb.push_back(cur_v);
            #1;
            exp_v = sb.pop_front();
            check($sformatf("v%0d_hit", i), 32'(hit), 32'(exp_v.e_hit));
            check($sformatf("v%0d_pred_taken", i), 32'(pred_taken), 32'(exp_v.e_pt));
            check($sformatf("v%0d_pred_target", i), pred_target, exp_v.e_ptgt);
            check($sformatf("v%0d_mispredict", i), 32'(mispredict), 32'(exp_v.e_mis));
            check($sformatf("v%0d_redirect_pc", i), redirect_pc, exp_v.e_redir);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_br_cnt", i), 32'(br_cnt), 32'(exp_v.e_br));
            check($sformatf("v%0d_mis_cnt", i), 32'(mis_cnt), 32'(exp_v.e_mc));
            $display("vec %0d: if_pc=0x%0h hit=%0b pt=%0b ptgt=0x%0h mis=%0b redir=0x%0h br=%0d mc=%0d",
                     i, exp_v.if_pc, hit, pred_taken, pred_target, mispredict, redirect_pc, br_cnt, mis_cnt);
        end

        // 20 mispredicting non-control updates: mis_cnt saturates at 15.
        exp_mc = 6;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle(32'h40);
            upd_valid = 1; upd_pc = 32'h1000; upd_pred_taken = 1; upd_pred_target = 32'h2000;
            #1;
            check($sformatf("sat%0d_mispredict", i), 32'(mispredict), 32'h1);
            @(posedge clk);
            #1;
            if (exp_mc < 15) exp_mc++;
            check($sformatf("sat%0d_mis_cnt", i), 32'(mis_cnt), 32'(exp_mc));
            $display("sat %0d: mis_cnt=%0d", i, mis_cnt);
        end
        check("sat_br_cnt", 32'(br_cnt), 32'd9);

        // Populate an entry so the asynchronous reset has something to wipe.
        @(negedge clk);
        idle(32'h40);
        upd_valid = 1; upd_branch = 1; upd_taken = 1; upd_pc = 32'h40; upd_target = 32'h20;
        @(negedge clk);
        idle(32'h40);
        #1;
        check("pre_rst_hit", 32'(hit), 32'h1);
        check("pre_rst_br_cnt", 32'(br_cnt), 32'd10);
        check("pre_rst_mis_cnt", 32'(mis_cnt), 32'd15);
        $display("pre-reset: hit=%0b br=%0d mc=%0d", hit, br_cnt, mis_cnt);

        // Mid-cycle reset with an allocating update in flight.
        @(negedge clk);
        idle(32'h40);
        upd_valid = 1; upd_jump = 1; upd_taken = 1; upd_pc = 32'h80; upd_target = 32'h100;
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_mis_cnt", 32'(mis_cnt), 32'h0);
        check("async_rst_br_cnt", 32'(br_cnt), 32'h0);
        check("async_rst_hit", 32'(hit), 32'h0);
        check("async_rst_pred_target", pred_target, 32'h44);
        $display("async reset: hit=%0b ptgt=0x%0h br=%0d mc=%0d", hit, pred_target, br_cnt, mis_cnt);
        @(negedge clk);
        idle(32'h80);
        rstn = 1'b1;
        #1;
        check("post_rst_hit_80", 32'(hit), 32'h0);
        check("post_rst_pred_target_80", pred_target, 32'h84);
        IF_pc = 32'h40;
        #1;
        check("post_rst_hit_40", 32'(hit), 32'h0);
        $display("post reset: hit=%0b", hit);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: table depth, power of 2, at least 2; IW = log2(ENTRIES).
REQ-002 SHALL have parameter TAG_W, default 8: stored tag width.
REQ-003 SHALL have parameter CTR_W, default 2: saturating direction-counter width, at least 1.
REQ-004 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port IF_pc, input, 32: fetch PC to look up.
REQ-008 SHALL have port hit, pred_taken, output, 1 each: entry matched; predict redirect.
REQ-009 SHALL have port pred_target, output, 32: next fetch PC.
REQ-010 SHALL have port upd_valid, upd_branch, upd_jump, upd_taken, input, 1 each: resolved control-flow info from MEM stage.
REQ-011 SHALL have port upd_pc, upd_target, input, 32 each: resolved instruction PC and its actual target.
REQ-012 SHALL have port upd_pred_taken (input, 1) and upd_pred_target (input, 32): the prediction carried down the pipe.
REQ-013 SHALL have port clear, input, 1: synchronous invalidate-all, for program upload.
REQ-014 SHALL have port mispredict (output, 1) and redirect_pc (output, 32): flush request and corrected PC.
REQ-015 SHALL have port br_cnt and mis_cnt, output, CNT_W each: resolved control-flow count and mispredict count.

Function
REQ-016 SHALL use index = pc[IW+1:2] and tag = pc[IW+1+TAG_W:IW+2]; each entry holds valid, tag, target[31:0], jmp, ctr[CTR_W-1:0].
REQ-017 SHALL drive lookup combinationally, zero latency: hit = valid and tag equal; pred_taken = hit and (jmp or ctr MSB); pred_target = target if pred_taken, else IF_pc+4 (mod 2^32).
REQ-018 SHALL define ctl = upd_valid and (upd_branch or upd_jump).
REQ-019 SHALL assert mispredict combinationally when upd_valid and any of these holds: upd_taken differs from upd_pred_taken; both are 1 and upd_target differs from upd_pred_target; (upd_branch or upd_jump) is 0 and upd_pred_taken is 1.
REQ-020 SHALL set redirect_pc = upd_target when ctl and upd_taken; else upd_pc+4.
REQ-021 SHALL, on update hit with ctl, saturate ctr up if taken and down if not, leaving it unchanged at all-ones or zero; when taken, overwrite target and jmp.
REQ-022 SHALL, on update miss with ctl and upd_taken, allocate: valid=1, tag, target, jmp=upd_jump, ctr=2^(CTR_W-1) (weak taken); a not-taken miss SHALL NOT allocate.
REQ-023 SHALL, when upd_valid with upd_branch=upd_jump=0 and the entry hits, clear that entry's valid (alias removal).
REQ-024 SHALL write the table at the clock edge: a same-cycle lookup to the updated index sees the old contents; the next cycle sees the new contents.
REQ-025 SHALL, on clear, zero all valid bits and reset all ctr to weak-not-taken (2^(CTR_W-1)-1) next edge; clear SHALL take priority over a same-cycle update, and stats SHALL be kept.
REQ-026 SHALL increment br_cnt when ctl, and mis_cnt when mispredict, each saturating at 2^CNT_W-1.

Reset
REQ-027 SHALL, while rstn=0 and independent of clk: all valid=0, all ctr=weak-not-taken, br_cnt=mis_cnt=0; hence hit=pred_taken=0 and pred_target=IF_pc+4.
REQ-028 SHALL discard an in-flight update when rstn is asserted mid-cycle, with no partial entry write.

Verification (ENTRIES=16, TAG_W=8, CTR_W=2)
REQ-029 SHALL check: after reset, IF_pc=0x40 -> hit=0, pred_taken=0, pred_target=0x44.
REQ-030 SHALL check: update pc=0x40 branch taken target=0x20, pred_taken=0 -> mispredict=1, redirect_pc=0x20; next cycle IF_pc=0x40 -> hit=1, pred_taken=1, pred_target=0x20.
REQ-031 SHALL check: then 3 not-taken updates at 0x40 with correct preds (1,0,0) -> ctr 2->1->0->0; pred_taken=0 after the first; mis_cnt increments only on the first.
REQ-032 SHALL check: IF_pc=0x440 (same index as 0x40, tag 0x11 vs 0x01) -> hit=0; non-control update pc=0x40 with pred_taken=1 -> mispredict=1, redirect 0x44, entry invalidated.
REQ-033 SHALL check: clear with a same-cycle taken update at 0x80 -> next cycle lookups at 0x40 and 0x80 both miss.
REQ-034 SHALL check: CNT_W=4, 20 mispredicting updates -> mis_cnt=15; rstn pulsed low mid-cycle -> mis_cnt=0 and hit=0 before the next clk edge.
